// File: rtl/mux_sel_sequencer.sv
// Stimulus sequencer for a 2:1 mux: steps {s,d1,d0} through 0..7, holding each vector HOLD cycles.
// Define MUX_SEQ_CHECK_EN to compile in the y_in checker; otherwise err_cnt stays 0.
module mux_sel_sequencer #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       d0,
  output logic       d1,
  output logic       s,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt
);

  localparam int unsigned CW = 4;
  localparam int unsigned VW = 3;
  localparam int unsigned EW = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [VW-1:0] VEC_LAST  = '1;
  localparam logic [EW-1:0] ERR_MAX   = '1;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic [VW-1:0] vec_nxt;
  logic [EW-1:0] err_nxt;
  logic          busy_nxt, done_nxt, pass_nxt;
  logic          mismatch_c;

  // Mismatch between the returned Y and what the mux should select for the current vector
`ifdef MUX_SEQ_CHECK_EN
  assign mismatch_c = (y_in != (s ? d1 : d0));
`else
  logic y_unused;
  assign y_unused   = y_in;
  assign mismatch_c = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    vec_nxt      = vec_idx;
    err_nxt      = err_cnt;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    pass_nxt     = pass;
    case (state)
      IDLE: begin
        busy_nxt     = 1'b0;
        vec_nxt      = '0;
        hold_cnt_nxt = '0;
        if (start) begin
          state_nxt = DRIVE;
          busy_nxt  = 1'b1;
          err_nxt   = '0;
          pass_nxt  = 1'b0;
        end
      end
      DRIVE: begin
        if (hold_cnt == HOLD_LAST) begin
          if (mismatch_c && (err_cnt != ERR_MAX)) begin
            err_nxt = err_cnt + EW'(1);
          end
          hold_cnt_nxt = '0;
          if (vec_idx == VEC_LAST) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            vec_nxt   = '0;
            pass_nxt  = (err_nxt == '0);
          end else begin
            vec_nxt = vec_idx + VW'(1);
          end
        end else begin
          hold_cnt_nxt = hold_cnt + CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt    = IDLE;
        busy_nxt     = 1'b0;
        vec_nxt      = '0;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // State and registered outputs; mux inputs follow the vector index bit-for-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      vec_idx  <= '0;
      d0       <= 1'b0;
      d1       <= 1'b0;
      s        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      vec_idx  <= vec_nxt;
      d0       <= vec_nxt[0];
      d1       <= vec_nxt[1];
      s        <= vec_nxt[2];
      busy     <= busy_nxt;
      done     <= done_nxt;
      pass     <= pass_nxt;
      err_cnt  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer with a scoreboard of expected run results.
module tb_mux_sel_sequencer;

  localparam int unsigned HOLD = 4;
  localparam int unsigned RUN  = 8 * HOLD;
`ifdef MUX_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, y_in;
  logic       d0, d1, s, busy, done, pass;
  logic [2:0] vec_idx;
  logic [3:0] err_cnt;
  logic [1:0] mode;

  typedef struct packed {
    logic [3:0] err;
    logic       pass;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mux_sel_sequencer #(.HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
    .d0(d0), .d1(d1), .s(s), .vec_idx(vec_idx),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Downstream mux model: 0 = correct mux, 1 = Y stuck at 0, 2 = inverted mux
  assign y_in = (mode == 2'd0) ? (s ? d1 : d0) :
                (mode == 2'd1) ? 1'b0 : ~(s ? d1 : d0);

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] md);
    int   e;
    logic [2:0] v;
    logic mx, y;
    exp_t r;
    e = 0;
    for (int i = 0; i < 8; i++) begin
      v  = 3'(i);
      mx = v[2] ? v[1] : v[0];
      y  = (md == 2'd0) ? mx : (md == 2'd1) ? 1'b0 : ~mx;
      if (y != mx) e++;
    end
    if (!CHK) e = 0;
    r.err  = 4'(e);
    r.pass = (e == 0);
    return r;
  endfunction

  task automatic run(input logic [1:0] md, input bit repulse, input int abort_vec);
    exp_t ex;
    bit   seen;
    seen = 1'b0;
    mode = md;
    @(negedge clk);
    start = 1'b1;
    sb.push_back(model(md));
    @(posedge clk);
    #1 start = 1'b0;
    for (int m = 0; m <= int'(RUN) + 8; m++) begin
      @(negedge clk);
      start = 1'b0;
      if (abort_vec >= 0 && m == abort_vec * int'(HOLD) + 1) begin
        check("abort_vec_before_reset", 8'(vec_idx), 8'(abort_vec));
        rst_n = 1'b0;
        #1;
        check("abort_outs", 8'({d0, d1, s, busy, done, pass}), 8'(0));
        check("abort_vec", 8'(vec_idx), 8'(0));
        check("abort_err", 8'(err_cnt), 8'(0));
        void'(sb.pop_front());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < int'(RUN) + 4; j++) begin
          @(negedge clk);
          check("abort_no_done", 8'({done, busy}), 8'(0));
        end
        return;
      end
      if (done) begin
        seen = 1'b1;
        ex   = sb.pop_front();
        check("latency", 8'(m), 8'(RUN));
        check("done_err", 8'(err_cnt), 8'(ex.err));
        check("done_pass", 8'(pass), 8'(ex.pass));
        check("done_busy", 8'(busy), 8'(0));
        break;
      end
      if (m < int'(RUN)) begin
        check("busy", 8'(busy), 8'(1));
        check("vec_idx", 8'(vec_idx), 8'(m / int'(HOLD)));
        check("vector", 8'({s, d1, d0}), 8'(m / int'(HOLD)));
        if (m == 0) check("start_clear", 8'({err_cnt, pass}), 8'(0));
      end
      if (repulse && m == 2 * int'(HOLD)) start = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: observed no done expected done at cycle %0d", RUN);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    @(negedge clk);
    check("done_pulse_len", 8'(done), 8'(0));
    check("idle_outs", 8'({s, d1, d0, busy, vec_idx}), 8'(0));
    repeat (3) @(negedge clk);
    check("hold_err", 8'(err_cnt), 8'(ex.err));
    check("hold_pass", 8'(pass), 8'(ex.pass));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_outs", 8'({d0, d1, s, busy, done, pass}), 8'(0));
    check("reset_vec_err", 8'({vec_idx, err_cnt}), 8'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 8'({busy, done, vec_idx}), 8'(0));

    run(2'd0, 1'b0, -1);
    run(2'd1, 1'b0, -1);
    run(2'd2, 1'b0, -1);
    run(2'd1, 1'b1, -1);
    run(2'd0, 1'b1, -1);
    run(2'd1, 1'b0, 3);
    run(2'd0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
